ps2_kbd_tx: RTL and testbench

PS2_KBD_TX -- requirements
Module: ps2_kbd_tx

---
 rtl/ps2_pkg.sv | 26 ++
 rtl/ps2_tx_fifo.sv | 53 +++++
 rtl/ps2_kbd_tx.sv | 159 +++++++++++++++
 tb/tb_ps2_kbd_tx.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// PS/2 keyboard transmitter: shared state encoding, frame constants
// and frame-building helpers.
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    LOW,
    HIGH,
    GAP
  } state_t;

  localparam int   FRAME_LEN = 11;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

  // Bit 0 goes out first, so the start bit sits at the LSB.
  function automatic logic [FRAME_LEN-1:0] build_frame(input logic [7:0] d);
    return {STOP_BIT, odd_parity(d), d, START_BIT};
  endfunction

endpackage

// File: rtl/ps2_tx_fifo.sv
// Synchronous show-ahead FIFO buffering scancodes ahead of the
// PS/2 frame engine.
module ps2_tx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             wr_en,
  output logic             full,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             push;
  logic             pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign push    = wr_en && !full;
  assign pop     = rd_en && !empty;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/ps2_kbd_tx.sv
// PS/2 keyboard-side transmitter: FIFO-fed 11-bit frame engine with
// host-inhibit abort and retransmission.
module ps2_kbd_tx
  import ps2_pkg::*;
#(
  parameter int HALF_PERIOD = 4000,
  parameter int GAP_CYCLES  = 8000,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       inhibit,
  output logic       ps2_clk,
  output logic       ps2_data,
  output logic       busy,
  output logic       done
);

  localparam int TMAX = (GAP_CYCLES > HALF_PERIOD) ?
                        GAP_CYCLES : HALF_PERIOD;
  localparam int TW   = $clog2(TMAX + 1);

  localparam logic [TW-1:0] T_HALF = TW'(HALF_PERIOD / 2 - 1);
  localparam logic [TW-1:0] T_FULL = TW'(HALF_PERIOD - 1);
  localparam logic [TW-1:0] T_GAP  = TW'(GAP_CYCLES - 1);
  localparam logic [3:0]    LAST   = 4'(FRAME_LEN - 1);

  state_t               state, state_nx;
  logic [TW-1:0]        tmr, tmr_nx;
  logic [3:0]           bit_cnt, cnt_nx;
  logic [FRAME_LEN-1:0] shreg, sh_nx;
  logic [7:0]           cur_byte, byte_nx;
  logic                 retain, retain_nx;
  logic                 done_nx;
  logic                 pop;
  logic                 full;
  logic                 empty;
  logic [7:0]           fifo_data;
  logic                 abort;

  ps2_tx_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_data (in_data),
    .wr_en   (in_valid),
    .full    (full),
    .rd_en   (pop),
    .rd_data (fifo_data),
    .empty   (empty)
  );

  assign abort = inhibit && (bit_cnt <= 4'd9);

  always_comb begin
    state_nx  = state;
    tmr_nx    = tmr + 1'b1;
    cnt_nx    = bit_cnt;
    sh_nx     = shreg;
    byte_nx   = cur_byte;
    retain_nx = retain;
    done_nx   = 1'b0;
    pop       = 1'b0;
    unique case (state)
      IDLE: begin
        tmr_nx = '0;
        if (!inhibit && (retain || !empty)) begin
          // An aborted byte takes priority over the FIFO head.
          byte_nx   = retain ? cur_byte : fifo_data;
          pop       = !retain;
          retain_nx = 1'b0;
          sh_nx     = build_frame(byte_nx);
          cnt_nx    = '0;
          state_nx  = SETUP;
        end
      end
      SETUP: begin
        if (abort) begin
          state_nx  = GAP;
          tmr_nx    = '0;
          retain_nx = 1'b1;
        end else if (tmr == T_HALF) begin
          state_nx = LOW;
          tmr_nx   = '0;
        end
      end
      LOW: begin
        if (abort) begin
          state_nx  = GAP;
          tmr_nx    = '0;
          retain_nx = 1'b1;
        end else if (tmr == T_FULL) begin
          state_nx = HIGH;
          tmr_nx   = '0;
        end
      end
      HIGH: begin
        if (abort) begin
          state_nx  = GAP;
          tmr_nx    = '0;
          retain_nx = 1'b1;
        end else if (tmr == T_HALF) begin
          tmr_nx = '0;
          if (bit_cnt == LAST) begin
            state_nx = GAP;
            done_nx  = 1'b1;
          end else begin
            cnt_nx   = bit_cnt + 1'b1;
            sh_nx    = {1'b1, shreg[FRAME_LEN-1:1]};
            state_nx = SETUP;
          end
        end
      end
      GAP: begin
        if (tmr == T_GAP) begin
          state_nx = IDLE;
          tmr_nx   = '0;
        end
      end
      default: begin
        state_nx = IDLE;
        tmr_nx   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      tmr      <= '0;
      bit_cnt  <= '0;
      shreg    <= '1;
      cur_byte <= '0;
      retain   <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_nx;
      tmr      <= tmr_nx;
      bit_cnt  <= cnt_nx;
      shreg    <= sh_nx;
      cur_byte <= byte_nx;
      retain   <= retain_nx;
      done     <= done_nx;
    end
  end

  // Lines decode from registered state only, so they never glitch.
  assign ps2_clk  = (state != LOW);
  assign ps2_data = (state == SETUP || state == LOW || state == HIGH) ?
                    shreg[0] : 1'b1;
  assign in_ready = !full;
  assign busy     = (state != IDLE) || !empty || retain;

endmodule

// File: tb/tb_ps2_kbd_tx.sv
// Scoreboard bench for ps2_kbd_tx: a PS/2 receiver-side monitor decodes
// frames and compares them with bytes the driver saw accepted.
module tb_ps2_kbd_tx;

  localparam int HP        = 8;
  localparam int GAPC      = 16;
  localparam int DEPTH     = 4;
  localparam int FRAME_CYC = 22 * HP;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic       inhibit;
  logic       ps2_clk;
  logic       ps2_data;
  logic       busy;
  logic       done;

  always #5 clk = ~clk;

  ps2_kbd_tx #(
    .HALF_PERIOD (HP),
    .GAP_CYCLES  (GAPC),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .inhibit  (inhibit),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .busy     (busy),
    .done     (done)
  );

  int         vectors = 0;
  int         errs    = 0;
  int         cyc     = 0;
  logic [7:0] exp_q[$];

  // Monitor state, also read by the driver.
  bit          in_frame  = 0;
  bit          pend_done = 0;
  bit          have_done = 0;
  int          nbits     = 0;
  int          hi_run    = 0;
  int          start_cyc = 0;
  int          done_cyc  = 0;
  int          nframes   = 0;
  int          naborts   = 0;
  logic        pclk      = 1'b1;
  logic        pdata     = 1'b1;
  logic [10:0] fbits     = '0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      errs++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic eval_frame();
    logic [7:0] b;
    nframes++;
    check("start_bit", 32'(fbits[0]), 32'd0);
    check("stop_bit", 32'(fbits[10]), 32'd1);
    if (exp_q.size() == 0) begin
      vectors++;
      errs++;
      $display("FAIL unexpected_frame: got %02h, expected none",
               fbits[8:1]);
    end else begin
      b = exp_q.pop_front();
      check("frame_byte", 32'(fbits[8:1]), 32'(b));
      check("parity", 32'(fbits[9]),
            32'(($countones(b) % 2) == 0));
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial forever begin
    @(negedge clk);
    if (rst) begin
      in_frame  = 0;
      pend_done = 0;
      have_done = 0;
      nbits     = 0;
      hi_run    = 0;
    end else begin
      if (ps2_data !== pdata)
        check("data_vs_clk",
              32'((pclk && ps2_clk) || (ps2_clk && ps2_data)), 32'd1);
      if (!in_frame && ps2_clk && !ps2_data) begin
        if (pend_done) check("done_missing", 32'd0, 32'd1);
        pend_done = 0;
        if (have_done)
          check("frame_gap", 32'((cyc - done_cyc) >= GAPC), 32'd1);
        in_frame  = 1;
        nbits     = 0;
        hi_run    = 0;
        start_cyc = cyc;
      end
      if (pclk && !ps2_clk) begin
        if (!in_frame) begin
          check("stray_clk_edge", 32'd1, 32'd0);
        end else begin
          fbits[nbits] = ps2_data;
          nbits++;
          if (nbits == 11) begin
            eval_frame();
            in_frame  = 0;
            pend_done = 1;
          end
        end
      end
      if (!ps2_clk) begin
        hi_run = 0;
      end else if (in_frame) begin
        hi_run++;
        if (hi_run > HP) begin
          in_frame = 0;
          naborts++;
        end
      end
      if (done) begin
        if (!pend_done) check("spurious_done", 32'd1, 32'd0);
        else check("frame_len", 32'(cyc - start_cyc), 32'(FRAME_CYC));
        pend_done = 0;
        have_done = 1;
        done_cyc  = cyc;
      end
    end
    pclk  = ps2_clk;
    pdata = ps2_data;
  end

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input logic [7:0] b);
    logic acc;
    in_data  = b;
    in_valid = 1'b1;
    acc      = in_ready;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    if (acc) exp_q.push_back(b);
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((busy || exp_q.size() != 0 || in_frame || pend_done)
           && n < budget) begin
      cycles(1);
      n++;
    end
    check("idle_timeout", 32'(n < budget), 32'd1);
  endtask

  task automatic wait_bits(input int k, input int budget);
    int n = 0;
    while (!(in_frame && nbits >= k) && n < budget) begin
      cycles(1);
      n++;
    end
    check("bit_wait_timeout", 32'(n < budget), 32'd1);
  endtask

  initial begin
    int ab0;
    int f0;
    rst      = 1'b1;
    in_valid = 1'b0;
    in_data  = 8'h00;
    inhibit  = 1'b0;
    cycles(3);
    rst = 1'b0;
    check("rst_ps2_clk", 32'(ps2_clk), 32'd1);
    check("rst_ps2_data", 32'(ps2_data), 32'd1);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);

    push(8'h1C);
    wait_idle(1000);

    push(8'hF0);
    push(8'h1C);
    wait_idle(2000);

    push(8'h00);
    push(8'hFF);
    push(8'h1B);
    push(8'hF0);
    push(8'h1B);
    check("in_ready_full", 32'(in_ready), 32'd0);
    push(8'hAA);
    wait_idle(4000);

    push(8'h1B);
    wait_bits(6, 500);
    ab0     = naborts;
    inhibit = 1'b1;
    cycles(3);
    check("inh_ps2_clk", 32'(ps2_clk), 32'd1);
    check("inh_ps2_data", 32'(ps2_data), 32'd1);
    cycles(37);
    inhibit = 1'b0;
    check("abort_seen", 32'(naborts), 32'(ab0 + 1));
    wait_idle(2000);

    push(8'h11);
    push(8'h22);
    push(8'h33);
    wait_bits(4, 500);
    cycles(2);
    rst = 1'b1;
    cycles(1);
    rst = 1'b0;
    exp_q.delete();
    check("mrst_ps2_clk", 32'(ps2_clk), 32'd1);
    check("mrst_ps2_data", 32'(ps2_data), 32'd1);
    check("mrst_in_ready", 32'(in_ready), 32'd1);
    check("mrst_busy", 32'(busy), 32'd0);
    f0 = nframes;
    cycles(500);
    check("mrst_no_frames", 32'(nframes), 32'(f0));

    for (int i = 0; i < 40; i++) begin
      push(8'($urandom_range(0, 255)));
      cycles($urandom_range(0, 150));
      if ($urandom_range(0, 4) == 0) begin
        inhibit = 1'b1;
        cycles($urandom_range(1, 40));
        inhibit = 1'b0;
      end
    end
    wait_idle(20000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got no completion, expected finish");
    $fatal(1);
  end

endmodule
